// File: rtl/ex_commit_stage_pkg.sv
// Shared CPU definitions: datapath defaults, ALU flag bit positions
// and branch-type encodings used by the decoder, ALU and commit stage.
package ex_commit_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_SIGN = 1;
  localparam int FLAG_CMP  = 2;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_JAL  = 3'd5
  } br_type_e;

  function automatic logic is_cond_br(logic [2:0] t);
    return (t >= 3'(BR_BEQ)) && (t <= 3'(BR_BGE));
  endfunction

endpackage

// File: rtl/ex_commit_stage_if.sv
// ALU-to-commit handshake, commit-to-writeback handshake,
// flush and fetch-redirect signals of the commit stage.
interface ex_commit_stage_if
  import ex_commit_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   alu_result;
  logic [2:0]        alu_flag;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic [2:0]        in_br_type;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_br_target;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;

  modport slave (
    input  in_valid, alu_result, alu_flag,
    input  in_rd, in_reg_write, in_br_type,
    input  in_pc, in_br_target, flush, out_ready,
    output in_ready, out_valid, out_result,
    output out_rd, out_reg_write,
    output redirect_valid, redirect_pc
  );

  modport master (
    output in_valid, alu_result, alu_flag,
    output in_rd, in_reg_write, in_br_type,
    output in_pc, in_br_target, flush, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_rd, out_reg_write,
    input  redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ex_commit_stage_branch_resolve.sv
// Combinational branch-taken decision from branch type and ALU flags.
module branch_resolve
  import ex_commit_stage_pkg::*;
(
  input  logic [2:0] br_type_i,
  input  logic [2:0] flag_i,
  output logic       taken_o
);

  logic zero;
  logic sign;
  logic unused_cmp;

  assign zero       = flag_i[FLAG_ZERO];
  assign sign       = flag_i[FLAG_SIGN];
  assign unused_cmp = flag_i[FLAG_CMP];

  always_comb begin
    taken_o = 1'b0;
    unique case (br_type_i)
      3'(BR_BEQ): taken_o = zero;
      3'(BR_BNE): taken_o = ~zero;
      3'(BR_BLT): taken_o = sign;
      3'(BR_BGE): taken_o = ~sign;
      3'(BR_JAL): taken_o = 1'b1;
      default:    taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_commit_stage.sv
// Commit stage: 2-entry in-order skid buffer with branch resolution
// at acceptance, one-cycle fetch redirect and wrong-path bubble.
module ex_commit_stage
  import ex_commit_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input logic clk,
  input logic rst,
  ex_commit_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } entry_t;

  entry_t          mem_q [2];
  entry_t          ent;
  entry_t          head;
  logic [1:0]      cnt_q, cnt_d;
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic            rdy_q, rdy_d;
  logic            rv_q, rv_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            taken;
  logic            accept;
  logic            drain;
  logic            jump;

  branch_resolve u_br (
    .br_type_i (bus.in_br_type),
    .flag_i    (bus.alu_flag),
    .taken_o   (taken)
  );

  assign accept = bus.in_valid & rdy_q & ~bus.flush;
  assign drain  = (cnt_q != 2'd0) & bus.out_ready
                & ~bus.flush;
  assign jump   = accept & taken;

  always_comb begin
    ent.result    = bus.alu_result;
    ent.rd        = bus.in_rd;
    ent.reg_write = bus.in_reg_write;
    if (bus.in_br_type == 3'(BR_JAL))
      ent.result = bus.in_pc + XLEN'(4);
    if (is_cond_br(bus.in_br_type))
      ent.reg_write = 1'b0;
  end

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    rdy_d  = rdy_q;
    rv_d   = 1'b0;
    rpc_d  = rpc_q;
    if (bus.flush) begin
      cnt_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
      rdy_d  = 1'b1;
    end else begin
      if (accept) tail_d = ~tail_q;
      if (drain)  head_d = ~head_q;
      unique case ({accept, drain})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
      // a taken branch leaves a one-cycle hole for wrong-path fetch
      rdy_d = (cnt_d != 2'd2) & ~jump;
      rv_d  = jump;
      if (jump) rpc_d = bus.in_br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      rdy_q  <= 1'b1;
      rv_q   <= 1'b0;
      rpc_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= rdy_d;
      rv_q   <= rv_d;
      rpc_q  <= rpc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[tail_q] <= ent;
  end

  assign head = mem_q[head_q];

  assign bus.in_ready       = rdy_q;
  assign bus.out_valid      = (cnt_q != 2'd0);
  assign bus.out_result     = bus.out_valid ? head.result : '0;
  assign bus.out_rd         = bus.out_valid ? head.rd : '0;
  assign bus.out_reg_write  = bus.out_valid & head.reg_write;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;

endmodule

// File: doc/ex_commit_stage.md
EX_COMMIT_STAGE -- requirements
Module: ex_commit_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of result, PC and target.
REQ-002 Parameter REG_AW, default 5, register-index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream ALU stage presents an instruction.
REQ-006 in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready.
REQ-007 alu_result  input  XLEN  ALU result for the instruction.
REQ-008 alu_flag  input  3  ALU flags: bit0 ZERO, bit1 SIGN, bit2 CMP.
REQ-009 in_rd / in_reg_write  input  REG_AW / 1  destination register and write enable.
REQ-010 in_br_type  input  3  0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 JAL; 6-7 treated as NONE.
REQ-011 in_pc / in_br_target  input  XLEN / XLEN  instruction PC and precomputed branch target.
REQ-012 flush  input  1  discard all buffered instructions.
REQ-013 out_valid  output  1  committed instruction available downstream.
REQ-014 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-015 out_result / out_rd / out_reg_write  output  XLEN / REG_AW / 1  committed writeback data.
REQ-016 redirect_valid / redirect_pc  output  1 / XLEN  one-cycle fetch-redirect request and target.

Function
REQ-017 Accepted instructions SHALL be held in a 2-entry in-order skid buffer (head, tail, count 0..2).
REQ-018 in_ready SHALL be registered and equal (count < 2) after the previous edge, with no combinational path from out_ready.
REQ-019 Latency: an instruction accepted into an empty buffer SHALL appear on out_valid the next cycle.
REQ-020 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-021 Accept and drain in the same cycle SHALL leave count unchanged; pointers wrap modulo 2.
REQ-022 Taken: BEQ if ZERO=1, BNE if ZERO=0, BLT if SIGN=1, BGE if SIGN=0, JAL always, NONE never.
REQ-023 Taken resolution SHALL occur at acceptance; redirect_valid SHALL pulse exactly one cycle after acceptance with redirect_pc = in_br_target.
REQ-024 For JAL, buffered result SHALL be in_pc + 4 (mod 2^XLEN), otherwise alu_result.
REQ-025 Branches (types 1-4) SHALL be stored with reg_write forced to 0.
REQ-026 After a taken acceptance, in_ready SHALL be 0 for exactly the following cycle (wrong-path bubble).
REQ-027 flush SHALL empty the buffer at the next edge; an input offered the same cycle is dropped; redirect_valid from a prior-cycle acceptance still fires.
REQ-028 flush together with a taken acceptance: flush wins, no redirect generated.
REQ-029 out_valid SHALL be 0 whenever count = 0; out_* data undefined-but-stable then, driven as 0.

Reset
REQ-030 On rst: count=0, pointers=0, out_valid=0, redirect_valid=0, redirect_pc=0, out_result=0, out_rd=0, out_reg_write=0, in_ready=1 the cycle after rst deasserts.
REQ-031 rst SHALL override flush and any handshake in the same cycle; buffered instructions are lost.

Structure
REQ-032 Branch-type encodings, flag bit indices (ZERO=0, SIGN=1, CMP=2) and XLEN default SHALL live in the shared CPU package, also used by the ALU and decoder.
REQ-033 Taken resolution SHALL be a combinational sub-module branch_resolve (br_type, flag -> taken).
REQ-034 Buffer entry SHALL be a packed record {result, rd, reg_write} defined locally.

Verification
REQ-035 Single ADD: alu_result=0x10, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=0x10, out_rd=3; no redirect.
REQ-036 Backpressure: out_ready=0, push 3 instructions -> first two accepted, in_ready=0 after second, outputs stable; release -> drained in order A, B then C accepted.
REQ-037 BEQ with ZERO=1, target 0x200 -> redirect_valid pulse 1 cycle later, redirect_pc=0x200, out_reg_write=0, in_ready low one cycle; BNE with ZERO=1 -> no redirect.
REQ-038 JAL at pc=0x1000, rd=1 -> out_result=0x1004, out_reg_write=1, redirect taken; pc=0xFFFFFFFC -> out_result=0x0.
REQ-039 Buffer full plus flush with in_valid=1 -> next cycle count=0, out_valid=0, input dropped, in_ready=1.
REQ-040 rst asserted mid-stream with count=2 and pending redirect -> all outputs at reset values next cycle, no redirect pulse.
